// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and mode constants for the single-clock FIFO family.
package fifo_pkg;
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers wrap at the last valid index so any depth works, not just powers of two.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/sfifo_ram.sv
// sfifo_ram: simple dual-port storage with synchronous write and enabled registered read.
module sfifo_ram #(
    parameter int DSIZE = 8,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [DSIZE-1:0] rdata
);
    logic [DSIZE-1:0] mem [DEPTH];

    // Same-address read and write returns the old word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo_pa.sv
// sync_fifo_pa: single-clock FIFO with arbitrary depth, registered occupancy flags,
// sticky error flags and an optional first-word-fall-through output stage.
module sync_fifo_pa
    import fifo_pkg::*;
#(
    parameter int DSIZE    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = MODE_STD,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CW = fifo_cw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);
    // In FWFT mode one word lives in the output register, so memory holds one fewer.
    localparam int MD = (FWFT == MODE_FWFT) ? DEPTH - 1 : DEPTH;
    localparam int AW = (MD > 1) ? $clog2(MD) : 1;

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_pa: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_pa: AF_LEVEL must be within 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_pa: AE_LEVEL must be within 0..DEPTH-1");
    end

    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count_nxt;
    logic          out_valid, out_valid_nxt, wr_ok, rd_ok, load, mem_re;

    // Memory words = count - out_valid; refill the output stage when it empties or is popped.
    always_comb begin
        wr_ok         = winc && !wfull;
        rd_ok         = rinc && !rempty;
        load          = (FWFT == MODE_FWFT) && (count > CW'(out_valid)) && (!out_valid || rd_ok);
        out_valid_nxt = load || (out_valid && !rd_ok);
        mem_re        = (FWFT == MODE_FWFT) ? load : rd_ok;
        count_nxt     = count + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            out_valid     <= 1'b0;
            wfull         <= 1'b0;
            walmost_full  <= 1'b0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (wr_ok) wptr <= AW'(ptr_inc(int'(wptr), MD));
            if (mem_re) rptr <= AW'(ptr_inc(int'(rptr), MD));
            count         <= count_nxt;
            out_valid     <= out_valid_nxt;
            wfull         <= count_nxt == CW'(DEPTH);
            walmost_full  <= count_nxt >= CW'(AF_LEVEL);
            rempty        <= (FWFT == MODE_FWFT) ? !out_valid_nxt : count_nxt == '0;
            ralmost_empty <= count_nxt <= CW'(AE_LEVEL);
            overflow      <= (winc && wfull) || (overflow && !clr_err);
            underflow     <= (rinc && rempty) || (underflow && !clr_err);
        end
    end

    sfifo_ram #(.DSIZE(DSIZE), .DEPTH(MD)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (wdata),
        .re    (mem_re),
        .raddr (rptr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_sync_fifo_pa.sv
// tb_sync_fifo_pa: three FIFO configurations driven in lockstep and compared every
// cycle against queue-based reference models.
module tb_sync_fifo_pa;
    logic       clk = 1'b0;
    logic       rst, winc, rinc, clr_err;
    logic [7:0] wdata;
    logic [7:0] rd [3];
    logic       wf [3], waf [3], re [3], rae [3], ov [3], un [3];
    logic [3:0] cnt0;
    logic [2:0] cnt1, cnt2;
    logic [3:0] cnt [3];
    int checks = 0, failures = 0;

    int dep [3] = '{8, 5, 4};
    int af  [3] = '{6, 4, 3};
    int ae  [3] = '{2, 1, 1};
    bit fw  [3] = '{1'b0, 1'b0, 1'b1};

    logic [7:0] mq [3][$];
    logic [7:0] mo [3];
    bit         mv [3], movf [3], munf [3];

    always #5 clk = ~clk;

    assign cnt[0] = cnt0;
    assign cnt[1] = {1'b0, cnt1};
    assign cnt[2] = {1'b0, cnt2};

    sync_fifo_pa #(.DSIZE(8), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_d8 (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wf[0]), .walmost_full(waf[0]),
        .rinc(rinc), .rdata(rd[0]), .rempty(re[0]), .ralmost_empty(rae[0]), .count(cnt0),
        .overflow(ov[0]), .underflow(un[0]), .clr_err(clr_err));
    sync_fifo_pa #(.DSIZE(8), .DEPTH(5), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_d5 (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wf[1]), .walmost_full(waf[1]),
        .rinc(rinc), .rdata(rd[1]), .rempty(re[1]), .ralmost_empty(rae[1]), .count(cnt1),
        .overflow(ov[1]), .underflow(un[1]), .clr_err(clr_err));
    sync_fifo_pa #(.DSIZE(8), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_fw4 (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .wfull(wf[2]), .walmost_full(waf[2]),
        .rinc(rinc), .rdata(rd[2]), .rempty(re[2]), .ralmost_empty(rae[2]), .count(cnt2),
        .overflow(ov[2]), .underflow(un[2]), .clr_err(clr_err));

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    // Reference: a queue of stored words plus, in FWFT mode, a visible output word.
    task automatic model_edge(input int k, input bit w, input bit r, input logic [7:0] d, input bit c, input bit rs);
        int  n;
        bit  full, empty, rd_ok, wr_ok;
        if (rs) begin
            mq[k].delete();
            mo[k] = '0;
            mv[k] = 1'b0;
            movf[k] = 1'b0;
            munf[k] = 1'b0;
            return;
        end
        n = mq[k].size() + int'(mv[k]);
        full = n == dep[k];
        empty = fw[k] ? !mv[k] : n == 0;
        rd_ok = r && !empty;
        wr_ok = w && !full;
        if (fw[k]) begin
            if (mq[k].size() > 0 && (!mv[k] || rd_ok)) begin
                mo[k] = mq[k].pop_front();
                mv[k] = 1'b1;
            end else if (rd_ok) mv[k] = 1'b0;
        end else if (rd_ok) mo[k] = mq[k].pop_front();
        if (wr_ok) mq[k].push_back(d);
        movf[k] = (w && full) ? 1'b1 : c ? 1'b0 : movf[k];
        munf[k] = (r && empty) ? 1'b1 : c ? 1'b0 : munf[k];
    endtask

    task automatic check_all(input int k);
        int n;
        n = mq[k].size() + int'(mv[k]);
        if (n > dep[k]) begin
            failures++;
            $error("FAIL model_bound[%0d] observed=%0d expected<=%0d", k, n, dep[k]);
        end
        chk("count", k, 32'(cnt[k]), 32'(n));
        chk("wfull", k, 32'(wf[k]), 32'(n == dep[k]));
        chk("rempty", k, 32'(re[k]), 32'(fw[k] ? !mv[k] : n == 0));
        chk("walmost_full", k, 32'(waf[k]), 32'(n >= af[k]));
        chk("ralmost_empty", k, 32'(rae[k]), 32'(n <= ae[k]));
        chk("overflow", k, 32'(ov[k]), 32'(movf[k]));
        chk("underflow", k, 32'(un[k]), 32'(munf[k]));
        chk("rdata", k, 32'(rd[k]), 32'(mo[k]));
    endtask

    task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c, input bit rs);
        winc = w;
        rinc = r;
        wdata = d;
        clr_err = c;
        rst = rs;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k, w, r, d, c, rs);
        #1;
        for (int k = 0; k < 3; k++) check_all(k);
    endtask

    initial begin
        {rst, winc, rinc, clr_err, wdata} = '0;
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        for (int i = 1; i <= 9; i++) step(1, 0, 8'(i), 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(1, 1, 8'hEE, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(1, 0, 8'h77, 0, 0);
        step(1, 0, 8'h78, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hA0 + c * 5 + i), 0, 0);
            for (int i = 0; i < 6; i++) step(0, 1, 8'h00, 0, 0);
        end
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 8'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h10 + i), 0, 0);
        step(1, 1, 8'h99, 0, 1);
        step(1, 0, 8'h3C, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
